// File: rtl/product_bcd_converter_pkg.sv
// Shared constants, state encoding and helpers for the product-to-BCD converter.
// The defaults match the 7-bit product of the upstream 3x4 array multiplier.
package product_bcd_converter_pkg;

   localparam int unsigned DefW      = 7;
   localparam int unsigned DefDigits = 3;

   typedef enum logic {
      StIdle = 1'b0,
      StConv = 1'b1
   } state_e;

   // Bit-counter width; a 1-bit input still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// Start/busy/done handshake plus data bus between the control logic and the converter.
// The control side uses the master modport; the converter uses the slave modport.
interface product_bcd_converter_if
   import product_bcd_converter_pkg::*;
#(
   parameter int unsigned W      = DefW,
   parameter int unsigned DIGITS = DefDigits
);

   logic                  start;
   logic [W-1:0]          P;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   BCD;

   modport master (
      output start,
      output P,
      input  busy,
      input  done,
      input  BCD
   );

   modport slave (
      input  start,
      input  P,
      output busy,
      output done,
      output BCD
   );

endinterface

// File: rtl/product_bcd_converter_bcd_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that the
// following left shift carries correctly into the next decimal digit.
module bcd_adjust (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the
// multiplier product; results land in a separate output register on completion.
module product_bcd_converter
   import product_bcd_converter_pkg::*;
#(
   parameter int unsigned W      = DefW,
   parameter int unsigned DIGITS = DefDigits
) (
   input  logic                   clk,
   input  logic                   rst,
   product_bcd_converter_if.slave bus
);

   localparam int unsigned     CntW    = cnt_width(W);
   localparam int unsigned     BcdW    = 4 * DIGITS;
   localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

   state_e            state_q, state_d;
   logic [W-1:0]      sr_q, sr_d;
   logic [BcdW-1:0]   wd_q, wd_d;
   logic [BcdW-1:0]   wd_adj;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              done_q, done_d;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_adjust u_bcd_adjust (
         .digit_i (wd_q[4*i +: 4]),
         .digit_o (wd_adj[4*i +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      wd_d    = wd_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               sr_d    = bus.P;
               wd_d    = '0;
               cnt_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            // Adjusted digits and the remaining input bits shift as one register.
            {wd_d, sr_d} = {wd_adj, sr_q} << 1;
            cnt_d        = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               bcd_d   = wd_d;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sr_q    <= '0;
         wd_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == StConv);
   assign bus.done = done_q;
   assign bus.BCD  = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: directed table, corner sequences, multiplier sweep
// and random conversions checked against a decimal-arithmetic reference.
module tb_product_bcd_converter;

   localparam int unsigned W      = 7;
   localparam int unsigned DIGITS = 3;

   typedef struct {
      int unsigned p;
      logic [3:0]  h;
      logic [3:0]  t;
      logic [3:0]  u;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   logic [11:0] exp_bcd;

   product_bcd_converter_if #(.W(W), .DIGITS(DIGITS)) bus ();

   product_bcd_converter #(
      .W      (W),
      .DIGITS (DIGITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] ref_bcd(input int unsigned v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Start sampled at edge 0; optional stray start with P=7 at edge glitch_edge.
   task automatic do_conv(input int unsigned p, input logic [11:0] expv, input int glitch_edge);
      bus.P     = 7'(p);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_e0", 32'(bus.busy), 32'd1);
      check("done_e0", 32'(bus.done), 32'd0);
      check("bcd_hold_e0", 32'(bus.BCD), 32'(exp_bcd));
      for (int k = 1; k < int'(W); k++) begin
         if (k == glitch_edge) begin
            bus.start = 1'b1;
            bus.P     = 7'd7;
         end
         @(negedge clk);
         bus.start = 1'b0;
         check($sformatf("busy_e%0d", k), 32'(bus.busy), 32'd1);
         check($sformatf("done_e%0d", k), 32'(bus.done), 32'd0);
         check($sformatf("bcd_hold_e%0d", k), 32'(bus.BCD), 32'(exp_bcd));
      end
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd1);
      check("busy_end", 32'(bus.busy), 32'd0);
      check($sformatf("bcd_p%0d", p), 32'(bus.BCD), 32'(expv));
      exp_bcd = expv;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_done", 32'(bus.done), 32'd0);
         check("idle_busy", 32'(bus.busy), 32'd0);
         check("idle_bcd", 32'(bus.BCD), 32'(exp_bcd));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [10];
      int unsigned p;
      n_vec     = 0;
      n_err     = 0;
      exp_bcd   = '0;
      tbl[0] = '{105, 4'd1, 4'd0, 4'd5};
      tbl[1] = '{0,   4'd0, 4'd0, 4'd0};
      tbl[2] = '{127, 4'd1, 4'd2, 4'd7};
      tbl[3] = '{99,  4'd0, 4'd9, 4'd9};
      tbl[4] = '{1,   4'd0, 4'd0, 4'd1};
      tbl[5] = '{9,   4'd0, 4'd0, 4'd9};
      tbl[6] = '{10,  4'd0, 4'd1, 4'd0};
      tbl[7] = '{100, 4'd1, 4'd0, 4'd0};
      tbl[8] = '{64,  4'd0, 4'd6, 4'd4};
      tbl[9] = '{119, 4'd1, 4'd1, 4'd9};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.P     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd", 32'(bus.BCD), 32'd0);
      idle_cycles(2);

      // Directed table, with a gap after each entry.
      for (int i = 0; i < 10; i++) begin
         do_conv(tbl[i].p, {tbl[i].h, tbl[i].t, tbl[i].u}, 0);
         idle_cycles(1);
      end

      // 127 then 99 started in the done cycle: second done 8 edges after the first.
      do_conv(127, 12'h127, 0);
      do_conv(99, 12'h099, 0);
      idle_cycles(2);

      // Stray start with P=7 at edge 3 during a conversion of 42.
      do_conv(42, 12'h042, 3);
      idle_cycles(W + 2);

      // Reset asserted between edges 3 and 4 of a conversion of 88.
      bus.P     = 7'd88;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(bus.busy), 32'd0);
      check("async_rst_done", 32'(bus.done), 32'd0);
      check("async_rst_bcd", 32'(bus.BCD), 32'd0);
      exp_bcd = '0;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(W + 2);
      do_conv(88, 12'h088, 0);

      // Every multiplier product, back to back.
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_conv(a * b, ref_bcd(a * b), 0);
         end
      end
      idle_cycles(1);

      // Random values, gaps and occasional stray starts.
      repeat (40) begin
         p = $urandom_range(0, 127);
         idle_cycles($urandom_range(0, 3));
         do_conv(p, ref_bcd(p), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
      end
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
